axis_frame_arbiter: RTL and testbench
=====================================

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, tdata width in bits.
REQ-002 Parameter KEEP_W, default DATA_W/8, tkeep width.
REQ-003 Parameter USER_W, default 1, tuser width.
REQ-004 Parameter CNT_W, default 16, width of per-source frame counters.
REQ-005 Port aclk, input, 1, sole clock; all state on rising edge.
REQ-006 Port aresetn, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 Ports s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser, in/out/in/in/in/in, 1/1/DATA_W/KEEP_W/1/USER_W, requester 0 AXIS slave.
REQ-008 Ports s1_axis_tvalid/tready/tdata/tkeep/tlast/tuser, same directions and widths, requester 1 AXIS slave.
REQ-009 Ports m_axis_tvalid/tready/tdata/tkeep/tlast/tuser, out/in/out/out/out/out, 1/1/DATA_W/KEEP_W/1/USER_W, master toward the shared FIFO.
REQ-010 Port m_axis_tid, output, 1, index of the source currently granted.
REQ-011 Ports frame_cnt0, frame_cnt1, output, CNT_W, completed frames forwarded per source.
REQ-012 Port busy, output, 1, high while a grant is held.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT0 and GRANT1, with a 1-bit last_grant register.
REQ-014 In IDLE with exactly one sX_tvalid high, the block SHALL move to GRANTX on the next edge.
REQ-015 In IDLE with both valid, the block SHALL grant the source not equal to last_grant (round robin).
REQ-016 In IDLE with no valid, the block SHALL remain in IDLE.
REQ-017 In GRANTX, m_axis_tvalid/tdata/tkeep/tlast/tuser SHALL combinationally equal sX's, and sX_axis_tready SHALL equal m_axis_tready (zero-latency datapath).
REQ-018 The non-granted source's tready SHALL be 0 in GRANT states, and both treadys SHALL be 0 in IDLE.
REQ-019 In IDLE, m_axis_tvalid SHALL be 0; m_axis_tdata/tkeep/tlast/tuser SHALL be 0.
REQ-020 The grant SHALL be held until a handshake (m_axis_tvalid & m_axis_tready) with tlast=1 on the granted source; no mid-frame switch.
REQ-021 On that tlast handshake, the FSM SHALL return to IDLE, set last_grant=X and increment frame_cntX by 1, wrapping modulo 2^CNT_W.
REQ-022 One IDLE bubble cycle SHALL occur between consecutive frames, giving a minimum 1-cycle gap.
REQ-023 A single-beat frame (tlast on first beat) SHALL occupy exactly one GRANT cycle when m_axis_tready=1.
REQ-024 The granted source dropping tvalid mid-frame SHALL NOT release the grant; m_axis_tvalid follows it low.
REQ-025 m_axis_tready low SHALL stall the granted source with no state change; data SHALL stay stable per AXIS rules via the pass-through.
REQ-026 m_axis_tid SHALL be 0 in GRANT0, 1 in GRANT1, and 0 in IDLE; busy SHALL be 1 exactly in GRANT0/GRANT1.
REQ-027 frame_cnt0 and frame_cnt1 SHALL be registered, and their increments SHALL never occur in the same cycle.

Reset
REQ-028 Asserting aresetn low SHALL immediately set state=IDLE, last_grant=1 (source 0 wins the first tie), frame_cnt0=frame_cnt1=0.
REQ-029 During reset all tvalid/tready outputs SHALL be 0, including when reset is asserted mid-frame; the partial frame is abandoned and counters are not incremented.
REQ-030 After deassertion, the first arbitration SHALL occur on the first rising edge with aresetn high.

Verification
REQ-031 Both sources continuously offer 4-beat frames, m_axis_tready=1 -> grant order 0,1,0,1; m_axis_tid matches; each frame is 4 beats plus 1 bubble; after 4 frames frame_cnt0=2 and frame_cnt1=2.
REQ-032 Only source 1 valid, three 2-beat frames -> three consecutive GRANT1 periods; frame_cnt1=3, frame_cnt0=0; s0_axis_tready stays 0.
REQ-033 m_axis_tready toggles 1010 during an 8-beat source-0 frame while source 1 is valid -> no source-1 beat appears before the source-0 tlast handshake; the 8 beats arrive in order with data intact.
REQ-034 Source 0 sends single-beat frames back-to-back while source 1 is idle -> one beat every 2 cycles; frame_cnt0 increments each beat.
REQ-035 CNT_W=4 with 17 source-0 frames -> frame_cnt0 wraps to 1.
REQ-036 aresetn is pulsed low at beat 3 of a 6-beat source-1 frame -> outputs go 0 asynchronously, counters read 0, and the first post-reset tie is granted to source 0.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// Two-source AXI-Stream frame arbiter. It grants one source at a time in
// round-robin order and holds the grant for a whole frame. The datapath is a
// zero-latency pass-through. It keeps a completed-frame counter per source.
module axis_frame_arbiter #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic [USER_W-1:0] s0_axis_tuser,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic [USER_W-1:0] s1_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tid,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] frame_cnt0_q, frame_cnt0_d;
  logic [CNT_W-1:0] frame_cnt1_q, frame_cnt1_d;

  // State, round-robin pointer and frame counters.
  // Source 0 wins the first tie after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      frame_cnt0_q <= '0;
      frame_cnt1_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
    end
  end

  // Pass-through mux. The granted source drives the master. Everything is zero in IDLE.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = '0;
    m_axis_tid     = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    busy           = 1'b0;
    case (state_q)
      GRANT0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
        busy           = 1'b1;
      end
      GRANT1: begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tid     = 1'b1;
        s1_axis_tready = m_axis_tready;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  // Arbitration in IDLE. Release the grant only on a handshaken tlast.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (s0_axis_tvalid) begin
          state_d = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          frame_cnt0_d = frame_cnt0_q + CNT_W'(1);
        end
      end
      GRANT1: begin
        if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          frame_cnt1_d = frame_cnt1_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter. Directed frame scenarios are compared every
// cycle against a behavioural model. Literal checks pin the model.
module tb_axis_frame_arbiter;
  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int USER_W = 1;
  localparam int CNT_W  = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              s0_axis_tvalid = 1'b0, s0_axis_tready;
  logic [DATA_W-1:0] s0_axis_tdata = '0;
  logic [KEEP_W-1:0] s0_axis_tkeep = '0;
  logic              s0_axis_tlast = 1'b0;
  logic [USER_W-1:0] s0_axis_tuser = '0;
  logic              s1_axis_tvalid = 1'b0, s1_axis_tready;
  logic [DATA_W-1:0] s1_axis_tdata = '0;
  logic [KEEP_W-1:0] s1_axis_tkeep = '0;
  logic              s1_axis_tlast = 1'b0;
  logic [USER_W-1:0] s1_axis_tuser = '0;
  logic              m_axis_tvalid, m_axis_tready = 1'b1;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic [USER_W-1:0] m_axis_tuser;
  logic              m_axis_tid;
  logic [CNT_W-1:0]  frame_cnt0, frame_cnt1;
  logic              busy;

  axis_frame_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source generators. Each source has frames left, a frame length, a beat and a frame index.
  int left [2];
  int len  [2];
  int beat [2];
  int fidx [2];
  bit pause [2];
  bit toggle_rdy = 1'b0;
  bit hs [2];

  function automatic logic [31:0] beat_data(int s, int f, int b);
    return 32'hA000_0000 | (32'(s) << 24) | (32'(f) << 8) | 32'(b);
  endfunction

  task automatic drive();
    s0_axis_tvalid = (left[0] > 0) && !pause[0];
    s0_axis_tdata  = beat_data(0, fidx[0], beat[0]);
    s0_axis_tkeep  = 4'(beat[0]) ^ 4'hF;
    s0_axis_tlast  = (beat[0] == len[0] - 1);
    s0_axis_tuser  = 1'(beat[0]);
    s1_axis_tvalid = (left[1] > 0) && !pause[1];
    s1_axis_tdata  = beat_data(1, fidx[1], beat[1]);
    s1_axis_tkeep  = 4'(beat[1] + 1);
    s1_axis_tlast  = (beat[1] == len[1] - 1);
    s1_axis_tuser  = 1'(beat[1] + 1);
    if (toggle_rdy) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic step();
    @(negedge aclk);
    hs[0] = s0_axis_tvalid & s0_axis_tready;
    hs[1] = s1_axis_tvalid & s1_axis_tready;
    @(posedge aclk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (hs[s]) begin
        beat[s]++;
        if (beat[s] == len[s]) begin
          beat[s] = 0;
          fidx[s]++;
          left[s]--;
        end
      end
    end
    drive();
  endtask

  // Model: the owner is -1 when idle, else a source index. It logs delivered beats and completed frames.
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_cnt [2];
  int cyc = 0;
  int log_src [$];
  logic [31:0] log_data [$];
  bit log_last [$];
  int end_cyc [$];
  int grant_seq [$];
  bit mv, ml;
  logic [31:0] md;

  initial forever begin
    @(posedge aclk or negedge aresetn);
    if (!aresetn) begin
      mdl_owner = -1;
      mdl_last  = 1;
      mdl_cnt[0] = 0;
      mdl_cnt[1] = 0;
    end else begin
      cyc++;
      if (mdl_owner < 0) begin
        if (s0_axis_tvalid && s1_axis_tvalid) mdl_owner = 1 - mdl_last;
        else if (s0_axis_tvalid) mdl_owner = 0;
        else if (s1_axis_tvalid) mdl_owner = 1;
      end else begin
        mv = (mdl_owner == 0) ? s0_axis_tvalid : s1_axis_tvalid;
        ml = (mdl_owner == 0) ? s0_axis_tlast  : s1_axis_tlast;
        md = (mdl_owner == 0) ? s0_axis_tdata  : s1_axis_tdata;
        if (mv && m_axis_tready) begin
          log_src.push_back(mdl_owner);
          log_data.push_back(md);
          log_last.push_back(ml);
          if (ml) begin
            end_cyc.push_back(cyc);
            grant_seq.push_back(mdl_owner);
            mdl_cnt[mdl_owner] = (mdl_cnt[mdl_owner] + 1) % (1 << CNT_W);
            mdl_last  = mdl_owner;
            mdl_owner = -1;
          end
        end
      end
    end
  end

  // On every falling edge, compare the DUT outputs against the model and the live inputs.
  initial forever begin
    @(negedge aclk);
    if (mdl_owner == 0) begin
      check("m_tvalid", 64'(m_axis_tvalid), 64'(s0_axis_tvalid));
      check("m_tdata",  64'(m_axis_tdata),  64'(s0_axis_tdata));
      check("m_tkeep",  64'(m_axis_tkeep),  64'(s0_axis_tkeep));
      check("m_tlast",  64'(m_axis_tlast),  64'(s0_axis_tlast));
      check("m_tuser",  64'(m_axis_tuser),  64'(s0_axis_tuser));
      check("s0_tready", 64'(s0_axis_tready), 64'(m_axis_tready));
      check("s1_tready", 64'(s1_axis_tready), 64'(0));
    end else if (mdl_owner == 1) begin
      check("m_tvalid", 64'(m_axis_tvalid), 64'(s1_axis_tvalid));
      check("m_tdata",  64'(m_axis_tdata),  64'(s1_axis_tdata));
      check("m_tkeep",  64'(m_axis_tkeep),  64'(s1_axis_tkeep));
      check("m_tlast",  64'(m_axis_tlast),  64'(s1_axis_tlast));
      check("m_tuser",  64'(m_axis_tuser),  64'(s1_axis_tuser));
      check("s0_tready", 64'(s0_axis_tready), 64'(0));
      check("s1_tready", 64'(s1_axis_tready), 64'(m_axis_tready));
    end else begin
      check("idle_out", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                         s0_axis_tready, s1_axis_tready}, 64'(0));
    end
    check("m_tid", 64'(m_axis_tid), 64'(mdl_owner == 1));
    check("busy",  64'(busy),       64'(mdl_owner >= 0));
    check("cnt0",  64'(frame_cnt0), 64'(mdl_cnt[0]));
    check("cnt1",  64'(frame_cnt1), 64'(mdl_cnt[1]));
  end

  task automatic clear_sources();
    for (int s = 0; s < 2; s++) begin
      left[s] = 0; len[s] = 1; beat[s] = 0; fidx[s] = 0; pause[s] = 1'b0;
    end
    toggle_rdy    = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic clear_logs();
    log_src.delete(); log_data.delete(); log_last.delete();
    end_cyc.delete(); grant_seq.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_sources();
    drive();
    repeat (2) step();
    clear_logs();
    aresetn = 1'b1;
  endtask

  task automatic run_until_done(input string name, input int max_cyc);
    int n = 0;
    while ((left[0] > 0 || left[1] > 0) && n < max_cyc) begin
      step();
      n++;
    end
    check({name, "_done"}, 64'(left[0] + left[1]), 64'(0));
    repeat (2) step();
  endtask

  initial begin
    clear_sources();
    // Reset state.
    do_reset();
    check("rst_cnt0", 64'(frame_cnt0), 64'(0));
    check("rst_cnt1", 64'(frame_cnt1), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mval", 64'(m_axis_tvalid), 64'(0));

    // Both sources offer two 4-beat frames each. Grants alternate, with 5 cycles per frame.
    left[0] = 2; len[0] = 4; left[1] = 2; len[1] = 4;
    drive();
    run_until_done("rr", 60);
    check("rr_nframes", 64'(grant_seq.size()), 64'(4));
    for (int i = 0; i < grant_seq.size(); i++) check("rr_order", 64'(grant_seq[i]), 64'(i % 2));
    for (int i = 1; i < end_cyc.size(); i++) check("rr_period", 64'(end_cyc[i] - end_cyc[i-1]), 64'(5));
    check("rr_cnt0", 64'(frame_cnt0), 64'(2));
    check("rr_cnt1", 64'(frame_cnt1), 64'(2));

    // Only source 1 offers three 2-beat frames.
    do_reset();
    left[1] = 3; len[1] = 2;
    drive();
    run_until_done("s1only", 40);
    check("s1_grants", 64'(grant_seq.size()), 64'(3));
    for (int i = 0; i < grant_seq.size(); i++) check("s1_order", 64'(grant_seq[i]), 64'(1));
    check("s1_cnt0", 64'(frame_cnt0), 64'(0));
    check("s1_cnt1", 64'(frame_cnt1), 64'(3));

    // An 8-beat source-0 frame runs under a toggling tready. Source 1 must wait for the source-0 tlast.
    do_reset();
    left[0] = 1; len[0] = 8; left[1] = 1; len[1] = 2;
    toggle_rdy = 1'b1;
    drive();
    run_until_done("stall", 80);
    check("stall_beats", 64'(log_src.size()), 64'(10));
    for (int i = 0; i < 8 && i < log_src.size(); i++) begin
      check("stall_src",  64'(log_src[i]),  64'(0));
      check("stall_data", 64'(log_data[i]), 64'(beat_data(0, 0, i)));
      check("stall_last", 64'(log_last[i]), 64'(i == 7));
    end
    for (int i = 8; i < log_src.size(); i++) check("stall_s1", 64'(log_src[i]), 64'(1));

    // Back-to-back single-beat frames from source 0 arrive one every 2 cycles.
    do_reset();
    left[0] = 5; len[0] = 1;
    drive();
    run_until_done("single", 40);
    check("single_cnt0", 64'(frame_cnt0), 64'(5));
    for (int i = 1; i < end_cyc.size(); i++) check("single_gap", 64'(end_cyc[i] - end_cyc[i-1]), 64'(2));

    // Seventeen frames wrap the 4-bit counter to 1.
    do_reset();
    left[0] = 17; len[0] = 1;
    drive();
    run_until_done("wrap", 80);
    check("wrap_cnt0", 64'(frame_cnt0), 64'(1));

    // If source 0 drops tvalid mid-frame, it keeps the grant while source 1 waits.
    do_reset();
    left[0] = 1; len[0] = 4; left[1] = 1; len[1] = 1;
    drive();
    for (int n = 0; n < 20 && beat[0] != 2; n++) step();
    check("drop_reach", 64'(beat[0]), 64'(2));
    pause[0] = 1'b1;
    drive();
    repeat (2) begin
      step();
      check("drop_busy",  64'(busy), 64'(1));
      check("drop_tid",   64'(m_axis_tid), 64'(0));
      check("drop_mval",  64'(m_axis_tvalid), 64'(0));
      check("drop_s1rdy", 64'(s1_axis_tready), 64'(0));
    end
    pause[0] = 1'b0;
    drive();
    run_until_done("drop", 30);
    check("drop_order_n", 64'(grant_seq.size()), 64'(2));
    if (grant_seq.size() == 2) check("drop_order", 64'({grant_seq[0][0], grant_seq[1][0]}), 64'(2'b01));

    // Asserting reset mid-frame abandons the frame. Afterwards, the first tie goes to source 0.
    do_reset();
    left[1] = 1; len[1] = 6;
    drive();
    for (int n = 0; n < 20 && beat[1] != 3; n++) step();
    check("arst_reach", 64'(beat[1]), 64'(3));
    check("arst_pre_busy", 64'(busy), 64'(1));
    #2 aresetn = 1'b0;
    #1;
    check("arst_mval",  64'(m_axis_tvalid), 64'(0));
    check("arst_s1rdy", 64'(s1_axis_tready), 64'(0));
    check("arst_busy",  64'(busy), 64'(0));
    check("arst_cnt1",  64'(frame_cnt1), 64'(0));
    clear_sources();
    drive();
    repeat (2) step();
    clear_logs();
    left[0] = 1; len[0] = 2; left[1] = 1; len[1] = 2;
    drive();
    #2 aresetn = 1'b1;
    run_until_done("arst", 30);
    check("arst_first", 64'(grant_seq.size() > 0 ? grant_seq[0] : 9), 64'(0));
    check("arst_cnt0",  64'(frame_cnt0), 64'(1));
    check("arst_cnt1b", 64'(frame_cnt1), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
